// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised modulo-MOD up/down counter with enable
// prescaler, synchronous clear, clamped parallel load and a registered
// terminal-count pulse.
// Optional feature: define UPDOWN_MOD_COUNTER_SAT_EN for saturating mode
// (steps that would wrap are suppressed and tc flags each suppressed step).
module updown_mod_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MOD      = 256,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    // With PRESCALE == 1 the prescaler register is a constant 0 and folds away.
    localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 64'd1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("updown_mod_counter: WIDTH must be 2..32");
        end
        if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
            $error("updown_mod_counter: MOD must be 2..2**WIDTH");
        end
        if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
            $error("updown_mod_counter: PRESCALE must be 1..65536");
        end
    endgenerate

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_next;
    logic [WIDTH-1:0] out_next;
    logic             tc_next;

    // Next-state: clear > load > prescaled step > hold.
    always_comb begin
        pre_next = pre;
        out_next = out;
        tc_next  = 1'b0;
        if (clear) begin
            pre_next = '0;
            out_next = '0;
        end else if (load) begin
            pre_next = '0;
            out_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (enable) begin
            if (pre == PRE_LAST) begin
                pre_next = '0;
                if (up_dn) begin
                    if (out == MAX_VAL) begin
                        tc_next = 1'b1;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
                        out_next = out;
`else
                        out_next = '0;
`endif
                    end else begin
                        out_next = out + WIDTH'(1);
                    end
                end else begin
                    if (out == '0) begin
                        tc_next = 1'b1;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
                        out_next = out;
`else
                        out_next = MAX_VAL;
`endif
                    end else begin
                        out_next = out - WIDTH'(1);
                    end
                end
            end else begin
                pre_next = pre + PRE_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
            out <= '0;
            tc  <= 1'b0;
        end else begin
            pre <= pre_next;
            out <= out_next;
            tc  <= tc_next;
        end
    end

endmodule
